dino_sprite_renderer: RTL and testbench

Pixel-pipeline client of the dino sprite ROM. For each VGA pixel position it decides whether the pixel lies inside the scaled dino bounding box, drives the 6-bit ROM address and 3-bit player state, and registers the returned sprite bit as the dino layer pixel. It also owns the per-frame player-state latch and the running-animation toggle, so the ROM sees a state that is stable for a whole video frame.

---
 rtl/dino_sprite_renderer.sv | 163 ++++++++++++++++
 tb/tb_dino_sprite_renderer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_sprite_renderer.sv
// -----------------------------------------------------------------------------
// dino_sprite_renderer
//
// Purpose:
//   Pixel-pipeline client of the dino sprite ROM. For every VGA pixel it tests
//   whether the pixel lies inside the scaled dino bounding box. It drives the
//   ROM texel address and the per-frame player state, then registers the
//   returned sprite bit as the dino layer pixel. The player state is latched
//   once per video frame, so the ROM sees a stable state for the whole frame.
//   The running animation alternates between two poses every ANIM_FRAMES
//   frames.
//
// Parameters:
//   SCALE_LOG2   - each texel covers (1<<SCALE_LOG2)^2 screen pixels
//   ANIM_FRAMES  - video frames per running-animation phase
//
// Ports:
//   clk             in   pixel clock
//   rst             in   synchronous active-high reset
//   i_hpos/i_vpos   in   current pixel position (stage 0)
//   i_frame_start   in   one-cycle pulse at start of vertical blank
//   i_dino_x/y      in   bounding box top-left corner
//   i_motion        in   00 run, 01 jump, 10 duck, 11 game over
//   i_sprite_color  in   combinational ROM texel for o_rom_counter/state
//   o_rom_counter   out  ROM address {rom_y, rom_x}           (stage 1)
//   o_player_state  out  ROM state select, stable per frame
//   o_dino_in_box   out  box hit                              (stage 2)
//   o_dino_pixel    out  box hit AND texel                    (stage 2)
// -----------------------------------------------------------------------------
module dino_sprite_renderer #(
  parameter int SCALE_LOG2  = 2,
  parameter int ANIM_FRAMES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_frame_start,
  input  logic [9:0] i_dino_x,
  input  logic [9:0] i_dino_y,
  input  logic [1:0] i_motion,
  input  logic       i_sprite_color,
  output logic [5:0] o_rom_counter,
  output logic [2:0] o_player_state,
  output logic       o_dino_in_box,
  output logic       o_dino_pixel
);

  localparam int          CNT_W    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [10:0] BOX_SIZE = 11'(8 << SCALE_LOG2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

  localparam logic [2:0] ST_RESTART  = 3'b000;
  localparam logic [2:0] ST_JUMPING  = 3'b001;
  localparam logic [2:0] ST_RUNNING1 = 3'b010;
  localparam logic [2:0] ST_RUNNING2 = 3'b011;
  localparam logic [2:0] ST_DUCKING  = 3'b100;
  localparam logic [2:0] ST_GAMEOVER = 3'b101;

  // ---------------------------------------------------------------------------
  // Stage 0: box test and texel address (combinational)
  // ---------------------------------------------------------------------------
  // The box end is computed in 11 bits so a box hanging past 1023 is clipped
  // rather than wrapping around to the left/top edge of the screen.
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_hit_x;
  logic        w_hit_y;
  logic        w_hit;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic [9:0]  w_dx_scaled;
  logic [9:0]  w_dy_scaled;
  logic [5:0]  w_rom_addr;

  assign w_x_end = {1'b0, i_dino_x} + BOX_SIZE;
  assign w_y_end = {1'b0, i_dino_y} + BOX_SIZE;

  assign w_hit_x = (i_hpos >= i_dino_x) && ({1'b0, i_hpos} < w_x_end);
  assign w_hit_y = (i_vpos >= i_dino_y) && ({1'b0, i_vpos} < w_y_end);
  assign w_hit   = w_hit_x && w_hit_y;

  // Offsets are only meaningful on a hit; a miss forces address 0 below.
  assign w_dx        = i_hpos - i_dino_x;
  assign w_dy        = i_vpos - i_dino_y;
  assign w_dx_scaled = w_dx >> SCALE_LOG2;
  assign w_dy_scaled = w_dy >> SCALE_LOG2;

  assign w_rom_addr = w_hit ? {w_dy_scaled[2:0], w_dx_scaled[2:0]} : 6'd0;

  // ---------------------------------------------------------------------------
  // Stage 1: ROM address register
  // ---------------------------------------------------------------------------
  logic r_hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rom_counter <= 6'd0;
      r_hit_q       <= 1'b0;
    end else begin
      o_rom_counter <= w_rom_addr;
      r_hit_q       <= w_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: capture the texel returned by the ROM during stage 1
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      o_dino_in_box <= 1'b0;
      o_dino_pixel  <= 1'b0;
    end else begin
      o_dino_in_box <= r_hit_q;
      o_dino_pixel  <= r_hit_q & i_sprite_color;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame player-state latch and running animation
  // ---------------------------------------------------------------------------
  // The state only moves on a frame_start edge, so motion requests arriving
  // mid-frame never change the sprite halfway down the screen. The running
  // pose uses the phase value from before this frame's counter update.
  logic [CNT_W-1:0] r_anim_cnt;
  logic             r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_player_state <= ST_RESTART;
      r_anim_cnt     <= '0;
      r_phase        <= 1'b0;
    end else if (i_frame_start) begin
      case (i_motion)
        2'b00: begin
          o_player_state <= r_phase ? ST_RUNNING2 : ST_RUNNING1;
          if (r_anim_cnt == CNT_LAST) begin
            r_anim_cnt <= '0;
            r_phase    <= ~r_phase;
          end else begin
            r_anim_cnt <= r_anim_cnt + CNT_W'(1);
          end
        end
        2'b01: begin
          o_player_state <= ST_JUMPING;
          r_anim_cnt     <= '0;
          r_phase        <= 1'b0;
        end
        2'b10: begin
          o_player_state <= ST_DUCKING;
          r_anim_cnt     <= '0;
          r_phase        <= 1'b0;
        end
        default: begin
          o_player_state <= ST_GAMEOVER;
          r_anim_cnt     <= '0;
          r_phase        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dino_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_dino_sprite_renderer
//
// Purpose:
//   Self-checking bench for dino_sprite_renderer. A combinational ROM model
//   answers o_rom_counter. Every driven pixel pushes its expected stage-1 and
//   stage-2 results into a scoreboard, which is popped as the pipeline
//   produces them. A small frame model predicts o_player_state.
// -----------------------------------------------------------------------------
module tb_dino_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] i_hpos = '0;
  logic [9:0] i_vpos = '0;
  logic       i_frame_start = 1'b0;
  logic [9:0] i_dino_x = 10'd100;
  logic [9:0] i_dino_y = 10'd200;
  logic [1:0] i_motion = 2'b00;
  logic       i_sprite_color;
  logic [5:0] o_rom_counter;
  logic [2:0] o_player_state;
  logic       o_dino_in_box;
  logic       o_dino_pixel;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] rom;
    logic       hit;
    logic       pix;
  } exp_t;

  exp_t q_s1[$];
  exp_t q_s2[$];

  // Frame-state model
  int         m_cnt   = 0;
  int         m_phase = 0;
  logic [2:0] m_state = 3'b000;

  dino_sprite_renderer #(.SCALE_LOG2(2), .ANIM_FRAMES(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_hpos         (i_hpos),
    .i_vpos         (i_vpos),
    .i_frame_start  (i_frame_start),
    .i_dino_x       (i_dino_x),
    .i_dino_y       (i_dino_y),
    .i_motion       (i_motion),
    .i_sprite_color (i_sprite_color),
    .o_rom_counter  (o_rom_counter),
    .o_player_state (o_player_state),
    .o_dino_in_box  (o_dino_in_box),
    .o_dino_pixel   (o_dino_pixel)
  );

  always #5 clk = ~clk;

  // Sprite icon: row index rom_y, bit index rom_x.
  function automatic logic rom_bit(input logic [5:0] addr);
    logic [7:0] row;
    case (addr[5:3])
      3'd0: row = 8'b00111100;
      3'd1: row = 8'b11110000;
      3'd2: row = 8'b10101010;
      3'd3: row = 8'b01010101;
      3'd4: row = 8'b11111111;
      3'd5: row = 8'b00011000;
      3'd6: row = 8'b01100110;
      default: row = 8'b11000011;
    endcase
    return row[addr[2:0]];
  endfunction

  assign i_sprite_color = rom_bit(o_rom_counter);

  // One clock with a pixel (and optional frame_start) presented.
  task automatic step(input int h, input int v, input logic fs, input logic [1:0] mot);
    exp_t e;
    exp_t o;
    int dx;
    int dy;
    dx = int'(i_dino_x);
    dy = int'(i_dino_y);
    i_hpos = 10'(h);
    i_vpos = 10'(v);
    i_frame_start = fs;
    i_motion = mot;
    e.hit = (h >= dx) && (h < dx + 32) && (v >= dy) && (v < dy + 32);
    e.rom = e.hit ? 6'((((v - dy) >> 2) & 7) * 8 + (((h - dx) >> 2) & 7)) : 6'd0;
    e.pix = e.hit & rom_bit(e.rom);
    q_s1.push_back(e);
    if (fs) begin
      if (mot == 2'b00) begin
        m_state = (m_phase != 0) ? 3'b011 : 3'b010;
        if (m_cnt == 5) begin
          m_cnt = 0;
          m_phase = 1 - m_phase;
        end else begin
          m_cnt++;
        end
      end else begin
        m_state = (mot == 2'b01) ? 3'b001 : (mot == 2'b10) ? 3'b100 : 3'b101;
        m_cnt = 0;
        m_phase = 0;
      end
    end
    @(posedge clk);
    #1;
    i_frame_start = 1'b0;
    if (q_s2.size() > 0) begin
      o = q_s2.pop_front();
      checks++;
      if (o_dino_in_box !== o.hit) begin
        errors++;
        $display("FAIL in_box: got %b want %b (t=%0t)", o_dino_in_box, o.hit, $time);
      end
      checks++;
      if (o_dino_pixel !== o.pix) begin
        errors++;
        $display("FAIL pixel: got %b want %b (t=%0t)", o_dino_pixel, o.pix, $time);
      end
    end
    o = q_s1.pop_front();
    checks++;
    if (o_rom_counter !== o.rom) begin
      errors++;
      $display("FAIL rom_counter: got %b want %b (t=%0t)", o_rom_counter, o.rom, $time);
    end
    q_s2.push_back(o);
    checks++;
    if (o_player_state !== m_state) begin
      errors++;
      $display("FAIL player_state: got %b want %b (t=%0t)", o_player_state, m_state, $time);
    end
  endtask

  // Reset for one clock while a pixel is presented; all outputs must clear.
  task automatic do_reset(input int h, input int v);
    rst = 1'b1;
    i_hpos = 10'(h);
    i_vpos = 10'(v);
    i_frame_start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({o_rom_counter, o_player_state, o_dino_in_box, o_dino_pixel} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rom=%b st=%b box=%b pix=%b want all 0",
               o_rom_counter, o_player_state, o_dino_in_box, o_dino_pixel);
    end
    q_s1.delete();
    q_s2.delete();
    m_cnt = 0;
    m_phase = 0;
    m_state = 3'b000;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, i_motion);
  endtask

  task automatic test_reset();
    i_dino_x = 10'd100;
    i_dino_y = 10'd200;
    do_reset(110, 210);
    idle(3);
  endtask

  task automatic test_box_hit();
    step(113, 206, 1'b0, 2'b00);
    checks++;
    if (o_rom_counter !== 6'b001_011) begin
      errors++;
      $display("FAIL box_hit_addr: got %b want 001011", o_rom_counter);
    end
    step(117, 206, 1'b0, 2'b00);
    checks++;
    if (o_dino_pixel !== 1'b0) begin
      errors++;
      $display("FAIL box_hit_texel3: got %b want 0", o_dino_pixel);
    end
    step(0, 0, 1'b0, 2'b00);
    checks++;
    if (o_dino_pixel !== 1'b1) begin
      errors++;
      $display("FAIL box_hit_texel4: got %b want 1", o_dino_pixel);
    end
    // Sweep a full scan line through the box
    for (int h = 95; h < 140; h++) step(h, 215, 1'b0, 2'b00);
    idle(2);
  endtask

  task automatic test_box_edges();
    int hs[4] = '{99, 100, 131, 132};
    logic exp_box[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(hs[i], 210, 1'b0, 2'b00);
      step(0, 0, 1'b0, 2'b00);
      checks++;
      if (o_dino_in_box !== exp_box[i]) begin
        errors++;
        $display("FAIL box_edge h=%0d: got %b want %b", hs[i], o_dino_in_box, exp_box[i]);
      end
    end
    step(110, 199, 1'b0, 2'b00);
    step(110, 232, 1'b0, 2'b00);
    step(110, 231, 1'b0, 2'b00);
    idle(2);
  endtask

  task automatic test_clipping();
    i_dino_x = 10'd1010;
    step(5, 206, 1'b0, 2'b00);
    checks++;
    if (o_rom_counter !== 6'd0) begin
      errors++;
      $display("FAIL clip_nowrap: got %b want 000000", o_rom_counter);
    end
    step(1023, 206, 1'b0, 2'b00);
    checks++;
    if (o_rom_counter !== 6'b001_011) begin
      errors++;
      $display("FAIL clip_edge_addr: got %b want 001011", o_rom_counter);
    end
    idle(2);
    i_dino_x = 10'd100;
  endtask

  task automatic test_animation();
    logic [2:0] want;
    do_reset(0, 0);
    for (int k = 1; k <= 13; k++) begin
      step(0, 0, 1'b1, 2'b00);
      want = (k <= 6 || k == 13) ? 3'b010 : 3'b011;
      checks++;
      if (o_player_state !== want) begin
        errors++;
        $display("FAIL anim pulse %0d: got %b want %b", k, o_player_state, want);
      end
      for (int i = 0; i < 3; i++) step(100 + 4 * i, 200 + k, 1'b0, 2'b00);
    end
  endtask

  task automatic test_motion_change();
    do_reset(0, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 1'b1, 2'b00);
      idle(2);
    end
    // Phase is 1: request jump mid-frame, state must hold
    for (int i = 0; i < 4; i++) step(110, 210, 1'b0, 2'b01);
    checks++;
    if (o_player_state !== 3'b011) begin
      errors++;
      $display("FAIL motion_hold: got %b want 011", o_player_state);
    end
    step(0, 0, 1'b1, 2'b01);
    checks++;
    if (o_player_state !== 3'b001) begin
      errors++;
      $display("FAIL motion_jump: got %b want 001", o_player_state);
    end
    step(0, 0, 1'b1, 2'b10);
    step(0, 0, 1'b1, 2'b11);
    idle(2);
    step(0, 0, 1'b1, 2'b00);
    checks++;
    if (o_player_state !== 3'b010) begin
      errors++;
      $display("FAIL motion_resume: got %b want 010", o_player_state);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1'b1, 2'b00);
      idle(2);
    end
    step(113, 206, 1'b0, 2'b00);
    step(117, 206, 1'b0, 2'b00);
    do_reset(118, 207);
    for (int k = 1; k <= 8; k++) begin
      step(112, 205, 1'b1, 2'b00);
      checks++;
      if (o_player_state !== ((k <= 6) ? 3'b010 : 3'b011)) begin
        errors++;
        $display("FAIL reset_anim pulse %0d: got %b", k, o_player_state);
      end
      step(120, 220, 1'b0, 2'b00);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] mot;
    for (int i = 0; i < 300; i++) begin
      mot = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step($urandom_range(90, 140), $urandom_range(190, 240),
           1'($urandom_range(0, 1)), mot);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_box_hit();
    test_box_edges();
    test_clipping();
    test_animation();
    test_motion_change();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
